// File: rtl/sram_sample_reader_pkg.sv
// Shared types and constants for the SRAM sample reader slice.
package sram_sample_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE,
    ST_ABORT
  } state_e;

  localparam logic [1:0] BYTEENABLE_ALL = 2'b11;

endpackage

// File: rtl/sram_sample_reader_if.sv
// SRAM arbiter read bus plus output sample stream, viewed from the reader (master) side.
interface sram_sample_reader_if #(
  parameter int unsigned ADDR_WIDTH = 20,
  parameter int unsigned DATA_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [1:0]            mem_byteenable;
  logic                  mem_read;
  logic [DATA_WIDTH-1:0] mem_readdata;
  logic                  mem_readdataready;
  logic                  mem_waitrequest;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output mem_address, mem_byteenable, mem_read, out_data, out_valid,
    input  mem_readdata, mem_readdataready, mem_waitrequest, out_ready
  );

  modport slave (
    input  mem_address, mem_byteenable, mem_read, out_data, out_valid,
    output mem_readdata, mem_readdataready, mem_waitrequest, out_ready
  );
endinterface

// File: rtl/sram_sample_reader_sync_fifo.sv
// Synchronous FIFO with flush; a push into a full FIFO is accepted when a pop frees the slot.
module sram_sample_reader_sync_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic             do_push, do_pop;

  assign count_o = wr_q - rd_q;
  assign full_o  = (count_o == (AW+1)'(DEPTH));
  assign empty_o = (wr_q == rd_q);
  assign data_o  = mem_q[rd_q[AW-1:0]];

  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + (AW+1)'(1);
    if (do_pop)  rd_d = rd_q + (AW+1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_q[AW-1:0]] <= data_i;
  end
endmodule

// File: rtl/sram_sample_reader.sv
// Streams a block of consecutive SRAM words onto a valid/ready output, with credit-limited reads.
module sram_sample_reader
  import sram_sample_reader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 20,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned LEN_WIDTH   = 21,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned MAX_PENDING = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [ADDR_WIDTH-1:0] start_address,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  sram_sample_reader_if.master  bus
);
  localparam int unsigned PW  = $clog2(MAX_PENDING + 1);
  localparam int unsigned FAW = $clog2(FIFO_DEPTH);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic [PW-1:0]         pending_q, pending_d;
  logic                  hold_q, hold_d;
  logic                  mem_read, accept, credit_ok, flush, push, pop;
  logic                  fifo_empty, fifo_full;
  logic [FAW:0]          fifo_count;
  logic [DATA_WIDTH-1:0] fifo_data;

  // Credit covers both in-flight reads and buffered words so the FIFO can never overflow.
  assign credit_ok = (32'(pending_q) + 32'(fifo_count) < FIFO_DEPTH) &&
                     (32'(pending_q) < MAX_PENDING) && !fifo_full;

  // A stalled request stays up regardless of credit until it is accepted.
  always_comb begin
    mem_read = 1'b0;
    unique case (state_q)
      ST_RUN:   mem_read = hold_q || ((remaining_q != '0) && credit_ok);
      ST_ABORT: mem_read = hold_q;
      default:  mem_read = 1'b0;
    endcase
  end

  assign accept = mem_read && !bus.mem_waitrequest;
  assign push   = bus.mem_readdataready && (state_q == ST_RUN || state_q == ST_DRAIN);
  assign pop    = bus.out_valid && bus.out_ready;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    pending_d   = pending_q;
    hold_d      = mem_read && bus.mem_waitrequest;
    flush       = 1'b0;

    if (accept) begin
      addr_d      = addr_q + ADDR_WIDTH'(1);
      remaining_d = remaining_q - LEN_WIDTH'(1);
    end

    unique case ({accept, bus.mem_readdataready})
      2'b10:   pending_d = pending_q + PW'(1);
      2'b01:   if (pending_q != '0) pending_d = pending_q - PW'(1);
      default: pending_d = pending_q;
    endcase

    unique case (state_q)
      ST_IDLE: if (enable) begin
        addr_d      = start_address;
        remaining_d = length;
        state_d     = (length == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        if (!enable) begin
          state_d = ST_ABORT;
          flush   = 1'b1;
        end else if (accept && remaining_q == LEN_WIDTH'(1)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!enable) begin
          state_d = ST_ABORT;
          flush   = 1'b1;
        end else if (pending_q == '0 && fifo_empty) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: if (!enable) state_d = ST_IDLE;
      ST_ABORT: begin
        flush = 1'b1;
        if (pending_q == '0 && !mem_read) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      pending_q   <= '0;
      hold_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      pending_q   <= pending_d;
      hold_q      <= hold_d;
    end
  end

  sram_sample_reader_sync_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(DATA_WIDTH)
  ) u_fifo (
    .clk_i  (clock),
    .rst_i  (reset),
    .flush_i(flush),
    .push_i (push),
    .data_i (bus.mem_readdata),
    .pop_i  (pop),
    .data_o (fifo_data),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  assign busy               = (state_q != ST_IDLE);
  assign done               = (state_q == ST_DONE);
  assign bus.mem_address    = addr_q;
  assign bus.mem_byteenable = BYTEENABLE_ALL;
  assign bus.mem_read       = mem_read;
  assign bus.out_data       = fifo_data;
  assign bus.out_valid      = !fifo_empty && (state_q != ST_ABORT);
endmodule

// File: tb/tb_sram_sample_reader.sv
// Self-checking bench: SRAM slave model with random stalls/latency and a block-level reference.
module tb_sram_sample_reader;
  localparam int unsigned AW = 20;
  localparam int unsigned DW = 16;
  localparam int unsigned LW = 21;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned MAXP = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic [AW-1:0] start_address;
  logic [LW-1:0] length;
  logic          busy, done;

  sram_sample_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  sram_sample_reader #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .FIFO_DEPTH(DEPTH), .MAX_PENDING(MAXP)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .start_address(start_address),
    .length(length), .busy(busy), .done(done), .bus(bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  int unsigned lat_min = 2, lat_max = 2;
  bit          wait_rand = 1'b0;
  int          ready_mode = 0;  // 0: always ready, 1: never, 2: random
  int unsigned cyc = 0, last_due = 0;

  typedef struct {
    int unsigned   due;
    logic [DW-1:0] data;
  } ret_t;
  ret_t          rq[$];
  logic [AW-1:0] acc_addr[$];
  logic [DW-1:0] got[$];
  int            stall_viol = 0, pend = 0, occ = 0, max_pend = 0, max_occ = 0;
  bit            prev_stall = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return a[15:0] ^ 16'hC3A5 ^ {a[19:16], 12'h000};
  endfunction

  function automatic int unsigned data_errors(input logic [AW-1:0] base, input int unsigned n);
    int unsigned e = 0;
    if (got.size() != int'(n)) e++;
    for (int unsigned i = 0; i < n && int'(i) < got.size(); i++)
      if (got[i] !== mem_word(base + AW'(i))) e++;
    return e;
  endfunction

  function automatic int unsigned addr_errors(input logic [AW-1:0] base, input int unsigned n);
    int unsigned e = 0;
    if (acc_addr.size() != int'(n)) e++;
    for (int unsigned i = 0; i < n && int'(i) < acc_addr.size(); i++)
      if (acc_addr[i] !== base + AW'(i)) e++;
    return e;
  endfunction

  // SRAM slave and stream sink, driven on the falling edge.
  always @(negedge clock) begin
    int unsigned lat, due;
    cyc++;
    case (ready_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = 1'b0;
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
    if (reset) begin
      rq.delete();
      last_due = 0;
      prev_stall = 1'b0;
      pend = 0;
      occ = 0;
      bus.mem_waitrequest = 1'b0;
      bus.mem_readdataready = 1'b0;
      bus.mem_readdata = '0;
    end else begin
      bus.mem_waitrequest = wait_rand ? 1'($urandom_range(0, 1)) : 1'b0;
      if (prev_stall && (bus.mem_read !== 1'b1 || bus.mem_address !== prev_addr)) stall_viol++;
      prev_stall = bus.mem_read && bus.mem_waitrequest;
      prev_addr = bus.mem_address;
      if (bus.mem_read === 1'b1 && !bus.mem_waitrequest) begin
        acc_addr.push_back(bus.mem_address);
        lat = $urandom_range(lat_min, lat_max);
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        rq.push_back('{due, mem_word(bus.mem_address)});
        pend++;
      end
      bus.mem_readdataready = 1'b0;
      bus.mem_readdata = '0;
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        bus.mem_readdataready = 1'b1;
        bus.mem_readdata = rq[0].data;
        void'(rq.pop_front());
        pend--;
        occ++;
      end
      if (bus.out_valid === 1'b1 && bus.out_ready) begin
        got.push_back(bus.out_data);
        occ--;
      end
    end
    if (pend > max_pend) max_pend = pend;
    if (occ > max_occ) max_occ = occ;
  end

  task automatic start_xfer(input logic [AW-1:0] a, input logic [LW-1:0] n);
    @(posedge clock); #1;
    acc_addr.delete();
    got.delete();
    occ = 0;
    stall_viol = 0;
    max_pend = 0;
    max_occ = 0;
    start_address = a;
    length = n;
    enable = 1'b1;
  endtask

  task automatic wait_done(input int unsigned budget, output bit ok);
    ok = 1'b0;
    for (int unsigned i = 0; i < budget; i++) begin
      @(posedge clock); #1;
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic end_xfer(input string name);
    enable = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL %s_idle: busy=%b done=%b required busy=0 done=0", name, busy, done);
    if (busy !== 1'b0 || done !== 1'b0) failures++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b0;
    start_address = '0;
    length = '0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bus.mem_read !== 1'b0 || bus.out_valid !== 1'b0) begin
      $display("FAIL reset_ctrl: busy=%b done=%b read=%b valid=%b required all 0",
               busy, done, bus.mem_read, bus.out_valid);
      failures++;
    end
    checks++;
    if (bus.mem_address !== '0 || bus.mem_byteenable !== 2'b11) begin
      $display("FAIL reset_bus: addr=%h be=%b required addr=0 be=11", bus.mem_address, bus.mem_byteenable);
      failures++;
    end
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_basic();
    bit ok;
    lat_min = 2; lat_max = 2; wait_rand = 1'b0; ready_mode = 0;
    start_xfer(20'h00010, 21'd5);
    wait_done(200, ok);
    checks++;
    if (!ok) begin $display("FAIL basic_done: done=%b required 1 within budget", done); failures++; end
    checks++;
    if (addr_errors(20'h00010, 5) != 0) begin
      $display("FAIL basic_addr: accepted=%0d required 5 from 0x00010", acc_addr.size()); failures++;
    end
    checks++;
    if (data_errors(20'h00010, 5) != 0) begin
      $display("FAIL basic_data: words=%0d errors=%0d required 5/0", got.size(), data_errors(20'h00010, 5));
      failures++;
    end
    checks++;
    if (busy !== 1'b1) begin $display("FAIL basic_busy: busy=%b required 1", busy); failures++; end
    end_xfer("basic");
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [AW-1:0] base;
    base = AW'($urandom_range(0, 20'hFFF00));
    lat_min = 1; lat_max = 1; wait_rand = 1'b0; ready_mode = 1;
    start_xfer(base, 21'd16);
    repeat (40) @(posedge clock);
    #1;
    checks++;
    if (acc_addr.size() != int'(DEPTH) || bus.mem_read !== 1'b0) begin
      $display("FAIL bp_stall: accepted=%0d read=%b required %0d and 0", acc_addr.size(), bus.mem_read, DEPTH);
      failures++;
    end
    ready_mode = 0;
    wait_done(300, ok);
    checks++;
    if (!ok) begin $display("FAIL bp_done: done=%b required 1 within budget", done); failures++; end
    checks++;
    if (addr_errors(base, 16) != 0 || data_errors(base, 16) != 0) begin
      $display("FAIL bp_data: accepted=%0d words=%0d required 16/16 in order", acc_addr.size(), got.size());
      failures++;
    end
    checks++;
    if (max_occ > int'(DEPTH)) begin
      $display("FAIL bp_overflow: buffered=%0d required <= %0d", max_occ, DEPTH); failures++;
    end
    end_xfer("bp");
  endtask

  task automatic test_random_wait();
    bit ok;
    logic [AW-1:0] base;
    int unsigned n;
    for (int unsigned it = 0; it < 4; it++) begin
      base = AW'($urandom());
      n = $urandom_range(1, 40);
      lat_min = 1; lat_max = 3; wait_rand = 1'b1; ready_mode = 2;
      start_xfer(base, LW'(n));
      wait_done(2000, ok);
      checks++;
      if (!ok || data_errors(base, n) != 0 || addr_errors(base, n) != 0) begin
        $display("FAIL rand_data[%0d]: done=%b words=%0d accepted=%0d required %0d in order",
                 it, done, got.size(), acc_addr.size(), n);
        failures++;
      end
      checks++;
      if (stall_viol != 0 || max_pend > int'(MAXP) || max_occ > int'(DEPTH)) begin
        $display("FAIL rand_rules[%0d]: stall_changes=%0d max_pending=%0d max_buffered=%0d required 0/<=%0d/<=%0d",
                 it, stall_viol, max_pend, max_occ, MAXP, DEPTH);
        failures++;
      end
      end_xfer("rand");
    end
    wait_rand = 1'b0;
  endtask

  task automatic test_wrap();
    bit ok;
    lat_min = 1; lat_max = 2; wait_rand = 1'b0; ready_mode = 0;
    start_xfer(20'hFFFFE, 21'd4);
    wait_done(200, ok);
    checks++;
    if (!ok || addr_errors(20'hFFFFE, 4) != 0 || data_errors(20'hFFFFE, 4) != 0) begin
      $display("FAIL wrap: done=%b accepted=%0d words=%0d required FFFFE..00001", done, acc_addr.size(), got.size());
      failures++;
    end
    if (acc_addr.size() == 4) begin
      checks++;
      if (acc_addr[2] !== 20'h00000) begin
        $display("FAIL wrap_addr2: addr=%h required 00000", acc_addr[2]); failures++;
      end
    end
    end_xfer("wrap");
  endtask

  task automatic test_zero_len_and_abort();
    bit ok;
    int viol = 0;
    int n_abort;
    start_xfer(20'h00100, 21'd0);
    @(posedge clock); #1;
    checks++;
    if (done !== 1'b1 || bus.mem_read !== 1'b0 || acc_addr.size() != 0) begin
      $display("FAIL zero_len: done=%b read=%b accepted=%0d required 1/0/0", done, bus.mem_read, acc_addr.size());
      failures++;
    end
    end_xfer("zero");

    lat_min = 3; lat_max = 3; wait_rand = 1'b0; ready_mode = 0;
    start_xfer(20'h00400, 21'd20);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clock); #1;
      if (got.size() >= 3) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin $display("FAIL abort_setup: words=%0d required >= 3", got.size()); failures++; end
    enable = 1'b0;
    @(posedge clock); #1;
    n_abort = got.size();
    checks++;
    if (busy !== 1'b1 || bus.out_valid !== 1'b0 || pend == 0) begin
      $display("FAIL abort_entry: busy=%b valid=%b outstanding=%0d required 1/0/>0", busy, bus.out_valid, pend);
      failures++;
    end
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clock); #1;
      if (done !== 1'b0) viol++;
      if (busy === 1'b0) begin ok = 1'b1; break; end
      if (bus.out_valid !== 1'b0) viol++;
    end
    checks++;
    if (!ok || viol != 0 || pend != 0) begin
      $display("FAIL abort_exit: idle=%b violations=%0d outstanding=%0d required 1/0/0", ok, viol, pend);
      failures++;
    end
    checks++;
    if (got.size() != n_abort) begin
      $display("FAIL abort_drop: words=%0d required %0d", got.size(), n_abort); failures++;
    end
    start_xfer(20'h00500, 21'd3);
    wait_done(200, ok);
    checks++;
    if (!ok || data_errors(20'h00500, 3) != 0) begin
      $display("FAIL after_abort: done=%b words=%0d required 3 fresh words", done, got.size()); failures++;
    end
    end_xfer("after_abort");
  endtask

  task automatic test_reset_mid();
    bit ok = 1'b0;
    lat_min = 3; lat_max = 3; wait_rand = 1'b0; ready_mode = 1;
    start_xfer(20'h00800, 21'd10);
    for (int i = 0; i < 50; i++) begin
      @(posedge clock); #1;
      if (pend >= 2) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin $display("FAIL rstmid_setup: outstanding=%0d required >= 2", pend); failures++; end
    reset = 1'b1;
    enable = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bus.mem_read !== 1'b0 || bus.out_valid !== 1'b0 ||
        bus.mem_address !== '0) begin
      $display("FAIL rstmid: busy=%b done=%b read=%b valid=%b addr=%h required all 0",
               busy, done, bus.mem_read, bus.out_valid, bus.mem_address);
      failures++;
    end
    reset = 1'b0;
    ready_mode = 0;
    repeat (2) @(posedge clock);
  endtask

  initial begin
    bus.out_ready = 1'b1;
    bus.mem_waitrequest = 1'b0;
    bus.mem_readdataready = 1'b0;
    bus.mem_readdata = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_random_wait();
    test_wrap();
    test_zero_len_and_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
